// File: rtl/addr_data_pipe.sv
// Address/data pipeline: a pointer that loads or auto-increments, a small
// register file accessed at that pointer, and one output delay stage.
module addr_data_pipe #(
  parameter int AW = 2,
  parameter int DW = 2
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          sr,
  input  logic [AW-1:0] addr_in,
  input  logic [DW-1:0] data_in,
  output logic [AW-1:0] addr_out,
  output logic [DW-1:0] data_out,
  output logic [AW-1:0] addr_out_q,
  output logic [DW-1:0] data_out_q
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic {
    STEP = 1'b0,
    LOAD = 1'b1
  } mode_e;

  mode_e mode;

  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic [AW-1:0] addr_dly_q;
  logic [DW-1:0] data_dly_q;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];

  // Control is a pure decode of sr; there is no stored state between cycles.
  assign mode = mode_e'(sr);

  // The memory access is indexed by the current pointer, so a LOAD writes at the
  // old address while the new one takes effect from the next edge.
  always_comb begin
    addr_d = addr_q + 1'b1;
    data_d = mem_q[addr_q];
    mem_d  = mem_q;
    case (mode)
      LOAD: begin
        addr_d        = addr_in;
        data_d        = data_in;
        mem_d[addr_q] = data_in;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      addr_q     <= '0;
      data_q     <= '0;
      addr_dly_q <= '0;
      data_dly_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      addr_q     <= addr_d;
      data_q     <= data_d;
      addr_dly_q <= addr_q;
      data_dly_q <= data_q;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign addr_out   = addr_q;
  assign data_out   = data_q;
  assign addr_out_q = addr_dly_q;
  assign data_out_q = data_dly_q;

endmodule

// File: tb/tb_addr_data_pipe.sv
// Directed bench for addr_data_pipe: each step drives one edge and checks all
// four outputs against hand-computed values.
module tb_addr_data_pipe;

  logic       clock = 1'b0;
  logic       rst   = 1'b1;
  logic       sr    = 1'b1;
  logic [1:0] addr_in = 2'd0;
  logic [1:0] data_in = 2'd0;
  logic [1:0] addr_out, data_out, addr_out_q, data_out_q;

  int checks = 0;
  int errors = 0;
  int pa = 0;
  int pd = 0;

  addr_data_pipe #(.AW(2), .DW(2)) dut (
    .clock      (clock),
    .rst        (rst),
    .sr         (sr),
    .addr_in    (addr_in),
    .data_in    (data_in),
    .addr_out   (addr_out),
    .data_out   (data_out),
    .addr_out_q (addr_out_q),
    .data_out_q (data_out_q)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one edge, then check outputs; delayed outputs expect the previous
  // step's expected values (or zero under reset).
  task automatic step(input string tag, input logic r, input logic s,
                      input int ai, input int di, input int ea, input int ed);
    int eqa, eqd;
    rst     = r;
    sr      = s;
    addr_in = 2'(ai);
    data_in = 2'(di);
    @(posedge clock);
    #1;
    eqa = r ? 0 : pa;
    eqd = r ? 0 : pd;
    check({tag, ".addr_out"},   int'(addr_out),   ea);
    check({tag, ".data_out"},   int'(data_out),   ed);
    check({tag, ".addr_out_q"}, int'(addr_out_q), eqa);
    check({tag, ".data_out_q"}, int'(data_out_q), eqd);
    pa = ea;
    pd = ed;
  endtask

  initial begin
    // Reset for two edges with active-looking inputs
    step("rst0", 1'b1, 1'b1, 3, 3, 0, 0);
    step("rst1", 1'b1, 1'b1, 3, 3, 0, 0);
    // Read mem[0..3] after reset; pointer wraps back to 0
    step("rd0", 1'b0, 1'b0, 0, 0, 1, 0);
    step("rd1", 1'b0, 1'b0, 0, 0, 2, 0);
    step("rd2", 1'b0, 1'b0, 0, 0, 3, 0);
    step("rd3", 1'b0, 1'b0, 0, 0, 0, 0);
    // Writes: mem[0]=2, mem[1]=3
    step("wr1", 1'b0, 1'b1, 1, 2, 1, 2);
    step("wr2", 1'b0, 1'b1, 2, 3, 2, 3);
    // Step/read with 3->0 wrap
    step("st1", 1'b0, 1'b0, 0, 0, 3, 0);
    step("st2", 1'b0, 1'b0, 0, 0, 0, 0);
    step("st3", 1'b0, 1'b0, 0, 0, 1, 2);
    step("st4", 1'b0, 1'b0, 0, 0, 2, 3);
    // Mid-operation reset must not write and must clear memory
    step("mrst", 1'b1, 1'b1, 2, 1, 0, 0);
    step("mr1", 1'b0, 1'b0, 0, 0, 1, 0);
    step("mr2", 1'b0, 1'b0, 0, 0, 2, 0);
    step("mr3", 1'b0, 1'b0, 0, 0, 3, 0);
    step("mr4", 1'b0, 1'b0, 0, 0, 0, 0);
    // Alternating load/step: write lands at the old address (0), mem[3] still 0
    step("al1", 1'b0, 1'b1, 3, 1, 3, 1);
    step("al2", 1'b0, 1'b0, 0, 0, 0, 0);
    step("al3", 1'b0, 1'b0, 0, 0, 1, 1);
    step("al4", 1'b0, 1'b0, 0, 0, 2, 0);
    step("al5", 1'b0, 1'b0, 0, 0, 3, 0);
    // Load with pointer at 3 writes mem[3]; following step reads it back
    step("al6", 1'b0, 1'b1, 3, 1, 3, 1);
    step("al7", 1'b0, 1'b0, 0, 0, 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
